// File: rtl/sha256_pkg.sv
// SHA-256 round engine shared definitions:
// round constants, IV, controller states and round functions.
package sha256_pkg;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] S0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] S1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] Ch(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] Maj(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_fn.sv
// One SHA-256 compression round, purely combinational:
// new a and new e from the working variables, K[t] and W[t].
module sha256_round_fn
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] a_new,
  output logic [31:0] e_new
);

  logic [31:0] t1;
  logic [31:0] t2;

  // mod 2^32 sums; carries fall off the 32-bit targets
  always_comb begin
    t1    = h + S1(e) + Ch(e, f, g) + k + w;
    t2    = S0(a) + Maj(a, b, c);
    a_new = t1 + t2;
    e_new = d + t1;
  end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression controller: sequences 64 rounds,
// drives external register A, keeps b..h, H0..H7 and t.
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         init,
  input  logic         blk_start,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  input  logic [31:0]  a_q,
  output logic [31:0]  a_next,
  output logic         a_load,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t      st;
  logic [31:0] b, c, d, e, f, g, h;
  logic [5:0]  t;
  logic [31:0] hs [8];
  logic [31:0] seed [8];
  logic [31:0] rnd_a;
  logic [31:0] rnd_e;

  sha256_round_fn u_fn (
    .a     (a_q),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .h     (h),
    .k     (K[t]),
    .w     (w_data),
    .a_new (rnd_a),
    .e_new (rnd_e)
  );

  // block seed: a simultaneous init makes the IV win
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      seed[i] = init ? IV[i] : hs[i];
    end
  end

  // handshake, status and register A drive
  always_comb begin
    w_ready = (st == ROUND);
    busy    = (st != IDLE);
    done    = (st == DONE);
    a_load  = 1'b0;
    a_next  = 32'd0;
    unique case (st)
      IDLE: begin
        if (blk_start) begin
          a_load = 1'b1;
          a_next = seed[0];
        end
      end
      ROUND: begin
        if (w_valid) begin
          a_load = 1'b1;
          a_next = rnd_a;
        end
      end
      FINAL: ;
      DONE:  ;
    endcase
  end

  assign digest = {hs[0], hs[1], hs[2], hs[3],
                   hs[4], hs[5], hs[6], hs[7]};

  // controller state, working variables and hash state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st <= IDLE;
      b  <= '0;
      c  <= '0;
      d  <= '0;
      e  <= '0;
      f  <= '0;
      g  <= '0;
      h  <= '0;
      t  <= '0;
      for (int i = 0; i < 8; i++) hs[i] <= IV[i];
    end else begin
      unique case (st)
        IDLE: begin
          if (init) begin
            for (int i = 0; i < 8; i++) hs[i] <= IV[i];
          end
          if (blk_start) begin
            b  <= seed[1];
            c  <= seed[2];
            d  <= seed[3];
            e  <= seed[4];
            f  <= seed[5];
            g  <= seed[6];
            h  <= seed[7];
            t  <= '0;
            st <= ROUND;
          end
        end
        ROUND: begin
          if (w_valid) begin
            h <= g;
            g <= f;
            f <= e;
            e <= rnd_e;
            d <= c;
            c <= b;
            b <= a_q;
            t <= t + 6'd1;
            if (t == LAST) st <= FINAL;
          end
        end
        FINAL: begin
          hs[0] <= hs[0] + a_q;
          hs[1] <= hs[1] + b;
          hs[2] <= hs[2] + c;
          hs[3] <= hs[3] + d;
          hs[4] <= hs[4] + e;
          hs[5] <= hs[5] + f;
          hs[6] <= hs[6] + g;
          hs[7] <= hs[7] + h;
          st    <= DONE;
        end
        DONE: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha256_round_engine.md
Name: sha256_round_engine

Overview:
- Compression-round datapath and controller of the SHA-256 core; sits directly upstream of the 32-bit working register A.
- Each round it computes the next value of a and drives it to register A via a_next/a_load, reading the current a back on a_q.
- Holds working variables b..h, the hash state H0..H7 and the 6-bit round counter.
- Consumes W_t from the message scheduler over a valid/ready handshake; produces the 256-bit digest after 64 rounds plus feed-forward.

Parameters:
- ROUNDS, 64, number of compression rounds; fixed by FIPS 180-4, not to be overridden.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- init  in  1  pulse; reload H0..H7 with IV (new message)
- blk_start  in  1  pulse; begin compressing one 512-bit block
- w_valid  in  1  W_t word valid
- w_data  in  32  W_t word
- w_ready  out  1  engine accepts W_t this cycle
- a_q  in  32  current value of register A
- a_next  out  32  next value for register A
- a_load  out  1  register A load enable
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, digest updated
- digest  out  256  {H0,H1,...,H7}, H0 in MSBs

Behaviour:
- Reset (async): state IDLE; b..h=0; t=0; H0..H7=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); w_ready=a_load=done=busy=0; a_next=0.
- Register A is external: loads a_next on an edge where a_load=1, so a_q is valid one cycle later.
- IDLE:
  - init=1: H<=IV.
  - blk_start=1: a_load=1, a_next=H0; b..h<=H1..H7; t<=0; go to ROUND.
  - init and blk_start together: IV takes priority for the H load and seeds the block (a_next=IV0, b..h<=IV1..IV7).
- ROUND:
  - w_ready=1.
  - On w_valid&w_ready:
    - T1=h+S1(e)+Ch(e,f,g)+K[t]+w_data
    - T2=S0(a_q)+Maj(a_q,b,c)
    - a_next=T1+T2, a_load=1
    - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a_q; t<=t+1.
  - All additions are mod 2^32 with carries discarded.
  - w_valid=0: stall; a_load=0, all state held; no timeout.
  - Word accepted with t==63: t wraps to 0, go to FINAL.
- FINAL (1 cycle): w_ready=0; H0<=H0+a_q, Hi<=Hi+{b..h}, mod 2^32; go to DONE.
- DONE (1 cycle): done=1; go to IDLE.
- busy=1 in ROUND/FINAL/DONE.
- init and blk_start are ignored unless in IDLE.
- digest is combinational from H; stable except in FINAL, init, or reset.
- Latency with w_valid held high: blk_start sampled at edge E0; W0..W63 accepted at E1..E64; H updated at E65; done high for the cycle after E65.
- Reset mid-block aborts the block: IV restored, no done.

Decomposition:
- Package sha256_pkg:
  - K[0:63] constant table
  - IV constants
  - state enum (IDLE, ROUND, FINAL, DONE)
  - functions S0, S1, Ch, Maj
- One sub-module sha256_round_fn: combinational T1/T2/a_next/e_next from (a,b,c,d,e,f,g,h,K,W). The engine keeps the sequencing.

Test Plan:
- Message "abc" (padded single block, W from reference scheduler model), init then blk_start, w_valid=1 -> done 65 edges after E0; digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-message block -> digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- "abc" with w_valid deasserted for 3 cycles every 7th word -> same digest; a_load=0 and state frozen during stalls; done delayed by the stall count.
- blk_start and init pulsed during ROUND (t=20) -> ignored, digest still correct.
- RST asserted at t=30 -> immediate IDLE, busy=0, digest=IV; a following init+"abc" block -> correct digest.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (blk_start twice, no init between) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
